// File: rtl/alu_mul_pkg.sv
// rtl/alu_mul_pkg.sv - shared encodings for the sequential shift-add multiplier
// Control words are packed zx,nx,zy,ny,f,no from MSB to LSB.
package alu_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    PH_ADD = 1'b0,
    PH_DBL = 1'b1
  } phase_t;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD    = 6'b0000_10;
  // y forced to all ones so that x & y returns x unchanged
  localparam logic [OP_W-1:0] OP_PASS_X = 6'b0011_00;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - team ALU: operand zero/negate stages, add or and, output negate
// zr flags a zero result, ng mirrors the result sign bit.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] x_z, x_n, y_z, y_n, res;

  always_comb begin
    x_z = zx ? '0 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? '0 : y;
    y_n = ny ? ~y_z : y_z;
    res = f ? (x_n + y_n) : (x_n & y_n);
    out = no ? ~res : res;
  end

  assign zr = (out == '0);
  assign ng = out[WIDTH-1];

endmodule

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - splits a packed ALU control word into the ALU's control pins
module alu_op_decode
  import alu_mul_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output logic            zx,
  output logic            nx,
  output logic            zy,
  output logic            ny,
  output logic            f,
  output logic            no
);

  assign {zx, nx, zy, ny, f, no} = op;

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add multiplier alternating accumulate and double phases on one ALU
// Define ALU_MUL_SEQ_OVF_EN to add the sticky ovf output.
module alu_mul_seq
  import alu_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
`ifdef ALU_MUL_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  state_t           state;
  phase_t           phase;
  logic [WIDTH-1:0] acc, m, q;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] alu_x, alu_y, alu_out;
  logic [OP_W-1:0]  alu_op;
  logic             zx, nx, zy, ny, f, no;
  logic             unused_zr, unused_ng;

  always_comb begin
    alu_x  = acc;
    alu_y  = m;
    alu_op = OP_PASS_X;
    if (phase == PH_DBL) begin
      alu_x  = m;
      alu_y  = m;
      alu_op = OP_ADD;
    end else if (q[0]) begin
      alu_op = OP_ADD;
    end
  end

  alu_op_decode u_dec (
    .op (alu_op),
    .zx (zx),
    .nx (nx),
    .zy (zy),
    .ny (ny),
    .f  (f),
    .no (no)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .x   (alu_x),
    .y   (alu_y),
    .zx  (zx),
    .nx  (nx),
    .zy  (zy),
    .ny  (ny),
    .f   (f),
    .no  (no),
    .out (alu_out),
    .zr  (unused_zr),
    .ng  (unused_ng)
  );

`ifdef ALU_MUL_SEQ_OVF_EN
  // An unsigned sum wrapped exactly when it came out smaller than an addend
  logic add_carry;
  assign add_carry = (alu_out < acc);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      phase   <= PH_ADD;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      m       <= '0;
      q       <= '0;
      count   <= '0;
`ifdef ALU_MUL_SEQ_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            count <= '0;
            phase <= PH_ADD;
            busy  <= 1'b1;
            state <= ST_ITER;
`ifdef ALU_MUL_SEQ_OVF_EN
            ovf   <= 1'b0;
`endif
          end
        end
        ST_ITER: begin
          if (phase == PH_ADD) begin
            if (q == '0 || count == CNT_MAX) begin
              product <= acc;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= ST_DONE;
            end else begin
              acc   <= alu_out;
              phase <= PH_DBL;
`ifdef ALU_MUL_SEQ_OVF_EN
              if (q[0] && add_carry) ovf <= 1'b1;
`endif
            end
          end else begin
            m     <= alu_out;
            q     <= q >> 1;
            count <= count + 1'b1;
            phase <= PH_ADD;
`ifdef ALU_MUL_SEQ_OVF_EN
            // A multiplicand bit falls off the top while later multiplier bits still need it
            if (m[WIDTH-1] && ((q >> 1) != '0)) ovf <= 1'b1;
`endif
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
